id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding front end for the five-stage pipeline; directly feeds the ALU's arg1, arg2, ALU_op and shamt inputs.
- Latches decoded instruction fields each cycle and resolves RAW hazards: forwards from EX/MEM and MEM/WB, and inserts one-cycle bubbles on load-use.
- Also applies the ID-stage write-through bypass and counts stall cycles.

---
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW-hazard handling: EX/MEM and MEM/WB operand
// forwarding, load-use bubble insertion, ID write-through bypass and stall counting.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
    input  logic [31:0]      id_imm,
    input  logic             id_use_imm,
    input  logic [4:0]       id_alu_op,
    input  logic [4:0]       id_shamt,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             flush,
    input  logic             exm_reg_write,
    input  logic             exm_mem_read,
    input  logic [4:0]       exm_rd,
    input  logic [31:0]      exm_result,
    input  logic             mwb_reg_write,
    input  logic [4:0]       mwb_rd,
    input  logic [31:0]      mwb_data,
    output logic [31:0]      arg1,
    output logic [31:0]      arg2,
    output logic [4:0]       alu_op,
    output logic [4:0]       shamt,
    output logic             ex_valid,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_store_data,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    logic             ex_valid_q, ex_valid_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic             ex_mem_write_q, ex_mem_write_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             use_imm_q, use_imm_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [4:0]       alu_op_q, alu_op_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [31:0]      rs_val_q, rs_val_d;
    logic [31:0]      rt_val_q, rt_val_d;
    logic [31:0]      imm_q, imm_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic             hz;
    logic             stall_int;
    logic [31:0]      fwd_rs;
    logic [31:0]      fwd_rt;

    function automatic logic [31:0] forward(
        input logic [4:0]  src,
        input logic [31:0] latched,
        input logic        e_we,
        input logic        e_ld,
        input logic [4:0]  e_rd,
        input logic [31:0] e_res,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_data
    );
        logic [31:0] v;
        v = latched;
        // A load in EX/MEM has no data yet; the load-use bubble covers that case.
        if (e_we && !e_ld && e_rd != '0 && e_rd == src) begin
            v = e_res;
        end else if (w_we && w_rd != '0 && w_rd == src) begin
            v = w_data;
        end
        return v;
    endfunction

    always_comb begin
        hz = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
             ((ex_rd_q == id_rs) | ((ex_rd_q == id_rt) & (~id_use_imm | id_mem_write)));
        stall_int = id_valid & hz & ~flush;
    end

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_reg_write_d = 1'b0;
        use_imm_d      = 1'b0;
        ex_rd_d        = '0;
        alu_op_d       = '0;
        shamt_d        = '0;
        rs_d           = '0;
        rt_d           = '0;
        rs_val_d       = '0;
        rt_val_d       = '0;
        imm_d          = '0;
        if (!(flush || stall_int)) begin
            ex_valid_d     = id_valid;
            ex_mem_read_d  = id_valid & id_mem_read;
            ex_mem_write_d = id_valid & id_mem_write;
            ex_reg_write_d = id_valid & id_reg_write;
            use_imm_d      = id_use_imm;
            ex_rd_d        = id_rd;
            alu_op_d       = id_alu_op;
            shamt_d        = id_shamt;
            rs_d           = id_rs;
            rt_d           = id_rt;
            imm_d          = id_imm;
            rs_val_d       = (mwb_reg_write && mwb_rd != '0 && mwb_rd == id_rs) ? mwb_data : id_rs_val;
            rt_val_d       = (mwb_reg_write && mwb_rd != '0 && mwb_rd == id_rt) ? mwb_data : id_rt_val;
        end
        stall_count_d = stall_count_q;
        if (stall_int && stall_count_q != '1) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_reg_write_q <= 1'b0;
            use_imm_q      <= 1'b0;
            ex_rd_q        <= '0;
            alu_op_q       <= '0;
            shamt_q        <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rs_val_q       <= '0;
            rt_val_q       <= '0;
            imm_q          <= '0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_reg_write_q <= ex_reg_write_d;
            use_imm_q      <= use_imm_d;
            ex_rd_q        <= ex_rd_d;
            alu_op_q       <= alu_op_d;
            shamt_q        <= shamt_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rs_val_q       <= rs_val_d;
            rt_val_q       <= rt_val_d;
            imm_q          <= imm_d;
            stall_count_q  <= stall_count_d;
        end
    end

    always_comb begin
        fwd_rs = forward(rs_q, rs_val_q, exm_reg_write, exm_mem_read, exm_rd, exm_result,
                         mwb_reg_write, mwb_rd, mwb_data);
        fwd_rt = forward(rt_q, rt_val_q, exm_reg_write, exm_mem_read, exm_rd, exm_result,
                         mwb_reg_write, mwb_rd, mwb_data);
        arg1          = fwd_rs;
        arg2          = use_imm_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        alu_op        = alu_op_q;
        shamt         = shamt_q;
        ex_valid      = ex_valid_q;
        ex_mem_read   = ex_mem_read_q;
        ex_mem_write  = ex_mem_write_q;
        ex_reg_write  = ex_reg_write_q;
        ex_rd         = ex_rd_q;
        stall         = stall_int;
        stall_count   = stall_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural model of the EX-stage contents is
// checked on every falling edge, plus hand-computed literal checks per scenario.
module tb_id_ex_stage;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_imm, id_mem_read, id_mem_write, id_reg_write, flush;
    logic [4:0]  id_rs, id_rt, id_rd, id_alu_op, id_shamt;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic        exm_reg_write, exm_mem_read, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_data;
    logic [31:0] arg1, arg2, ex_store_data;
    logic [4:0]  alu_op, shamt, ex_rd;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, stall;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_shamt(id_shamt),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .arg1(arg1), .arg2(arg2), .alu_op(alu_op), .shamt(shamt),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently held in EX, as an abstract record.
    typedef struct {
        logic        valid, mr, mw, rw, ui;
        logic [4:0]  rs, rt, rd, op, sh;
        logic [31:0] rsv, rtv, imm;
    } ex_t;

    ex_t m;
    int  m_cnt;

    function automatic ex_t empty_instr();
        ex_t e;
        e.valid = 0; e.mr = 0; e.mw = 0; e.rw = 0; e.ui = 0;
        e.rs = 0; e.rt = 0; e.rd = 0; e.op = 0; e.sh = 0;
        e.rsv = 0; e.rtv = 0; e.imm = 0;
        return e;
    endfunction

    function automatic bit m_stall();
        bit dep;
        dep = (m.rd == id_rs) || (m.rd == id_rt && (!id_use_imm || id_mem_write));
        return id_valid && !flush && m.valid && m.mr && m.rd != 0 && dep;
    endfunction

    function automatic logic [31:0] m_value(input logic [4:0] r, input logic [31:0] latched);
        if (r == 0) return latched;
        if (exm_reg_write && !exm_mem_read && exm_rd == r) return exm_result;
        if (mwb_reg_write && mwb_rd == r) return mwb_data;
        return latched;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = empty_instr();
            m_cnt = 0;
        end else begin
            ex_t n;
            n = empty_instr();
            if (m_stall() && m_cnt < MAXC) m_cnt++;
            if (!flush && !m_stall()) begin
                n.valid = id_valid;
                n.mr = id_valid & id_mem_read;
                n.mw = id_valid & id_mem_write;
                n.rw = id_valid & id_reg_write;
                n.ui = id_use_imm; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
                n.op = id_alu_op; n.sh = id_shamt; n.imm = id_imm;
                n.rsv = (mwb_reg_write && mwb_rd != 0 && mwb_rd == id_rs) ? mwb_data : id_rs_val;
                n.rtv = (mwb_reg_write && mwb_rd != 0 && mwb_rd == id_rt) ? mwb_data : id_rt_val;
            end
            m = n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check("m_ex_valid", 32'(ex_valid), 32'(m.valid));
            check("m_mem_read", 32'(ex_mem_read), 32'(m.mr));
            check("m_mem_write", 32'(ex_mem_write), 32'(m.mw));
            check("m_reg_write", 32'(ex_reg_write), 32'(m.rw));
            check("m_ex_rd", 32'(ex_rd), 32'(m.rd));
            check("m_alu_op", 32'(alu_op), 32'(m.op));
            check("m_shamt", 32'(shamt), 32'(m.sh));
            check("m_arg1", arg1, m_value(m.rs, m.rsv));
            check("m_arg2", arg2, m.ui ? m.imm : m_value(m.rt, m.rtv));
            check("m_store", ex_store_data, m_value(m.rt, m.rtv));
            check("m_stall", 32'(stall), 32'(m_stall()));
            check("m_count", 32'(stall_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_fwd();
        exm_reg_write = 0; exm_mem_read = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                            input logic [31:0] imm, input logic ui, input logic [4:0] op,
                            input logic mr, input logic mw, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_use_imm = ui;
        id_alu_op = op; id_shamt = rs ^ rt;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic id_idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; flush = 0;
        id_idle();
        clear_fwd();
        running = 1;
        repeat (2) step();
        check("rst_ex_valid", 32'(ex_valid), 32'h0);
        check("rst_count", 32'(stall_count), 32'h0);
        rst = 0;
        step();

        // add r3,r1,r2 followed by sub r4,r3,r1: rs value comes from EX/MEM
        drive_id(1, 3, 1, 4, 32'h5, 32'h9, 0, 0, 5'b00001, 0, 0, 1);
        step();
        id_idle();
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'h10;
        #1 check("fwd_exm_arg1", arg1, 32'h10);

        mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'hBB; exm_result = 32'hAA;
        #1 check("prio_exm", arg1, 32'hAA);
        exm_mem_read = 1;
        #1 check("prio_mwb", arg1, 32'hBB);
        step();
        clear_fwd();

        // lw r5 then add r6,r5,r0: one bubble, then operand from MEM/WB
        drive_id(1, 1, 5, 5, 32'h100, 0, 32'h4, 1, 5'b01110, 1, 0, 1);
        step();
        drive_id(1, 5, 0, 6, 32'h0, 32'h0, 0, 0, 5'b00000, 0, 0, 1);
        #1 check("lu_stall", 32'(stall), 32'h1);
        step();
        exm_reg_write = 1; exm_mem_read = 1; exm_rd = 5; exm_result = 32'hDEAD;
        #1 check("lu_bubble", 32'(ex_valid), 32'h0);
        check("lu_stall_drop", 32'(stall), 32'h0);
        check("lu_count", 32'(stall_count), 32'h1);
        step();
        id_idle();
        clear_fwd();
        mwb_reg_write = 1; mwb_rd = 5; mwb_data = 32'h1234;
        #1 check("lu_arg1", arg1, 32'h1234);
        check("lu_valid", 32'(ex_valid), 32'h1);
        check("lu_rd", 32'(ex_rd), 32'h6);
        step();
        clear_fwd();

        // same hazard with flush: no stall, bubble, counter untouched
        drive_id(1, 1, 5, 5, 32'h100, 0, 32'h4, 1, 5'b01110, 1, 0, 1);
        step();
        drive_id(1, 5, 0, 6, 32'h0, 32'h0, 0, 0, 5'b00000, 0, 0, 1);
        flush = 1;
        #1 check("fl_stall", 32'(stall), 32'h0);
        step();
        flush = 0;
        id_idle();
        #1 check("fl_bubble", 32'(ex_valid), 32'h0);
        check("fl_count", 32'(stall_count), 32'h1);
        step();

        // r0 is never forwarded
        drive_id(1, 0, 2, 7, 32'h0, 32'h3, 0, 0, 5'b00001, 0, 0, 1);
        step();
        id_idle();
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFFFF;
        #1 check("r0_arg1", arg1, 32'h0);
        step();
        clear_fwd();

        // sw with immediate offset: arg2 is imm, store data forwarded
        drive_id(1, 2, 7, 0, 32'h40, 32'h0, 32'h8, 1, 5'b01110, 0, 1, 0);
        step();
        id_idle();
        exm_reg_write = 1; exm_rd = 7; exm_result = 32'h77;
        #1 check("sw_arg2", arg2, 32'h8);
        check("sw_store", ex_store_data, 32'h77);
        check("sw_mw", 32'(ex_mem_write), 32'h1);
        step();
        clear_fwd();

        // write-through at latch time
        drive_id(1, 9, 10, 11, 32'h1, 32'h2, 0, 0, 5'b00010, 0, 0, 1);
        mwb_reg_write = 1; mwb_rd = 9; mwb_data = 32'h55;
        step();
        id_idle();
        clear_fwd();
        #1 check("wt_arg1", arg1, 32'h55);
        check("wt_arg2", arg2, 32'h2);
        step();

        // repeated load-use pairs drive the counter into saturation
        for (int i = 0; i < 20; i++) begin
            drive_id(1, 1, 12, 12, 32'h0, 0, 0, 1, 5'b01110, 1, 0, 1);
            step();
            drive_id(1, 3, 12, 13, 0, 0, 0, 0, 5'b00000, 0, 0, 1);
            step();
        end
        id_idle();
        #1 check("sat_count", 32'(stall_count), 32'(MAXC));
        step();

        // async reset while a stall is pending
        drive_id(1, 1, 14, 14, 32'h0, 0, 0, 1, 5'b01110, 1, 0, 1);
        step();
        drive_id(1, 14, 0, 15, 0, 0, 0, 0, 5'b00011, 0, 0, 1);
        #1 check("rs_pre_stall", 32'(stall), 32'h1);
        rst = 1;
        #1 check("rs_valid", 32'(ex_valid), 32'h0);
        check("rs_alu_op", 32'(alu_op), 32'h0);
        check("rs_rd", 32'(ex_rd), 32'h0);
        check("rs_count", 32'(stall_count), 32'h0);
        check("rs_stall", 32'(stall), 32'h0);
        step();
        rst = 0;
        id_idle();
        step();
        step();
        running = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
